// File: rtl/instr_fetch_unit.sv
// PC generator and fetch sequencer for a single-cycle-latency instruction memory.
// Issues one word per cycle, tags returned data with its PC, and halts on bad fetch addresses.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        RE_mem1,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {StBoot, StRun, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic        inflight_q, inflight_d;
    logic [31:0] pc_plus4;
    logic        addr_bad;

    assign pc_plus4 = pc_q + 32'd4;
    assign addr_bad = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= IMEM_DEPTH);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        inflight_d = 1'b0;
        RE_mem1    = 1'b0;
        case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (addr_bad) begin
                    state_d    = StFault;
                    inflight_d = inflight_q && stall_in;
                end else if (stall_in) begin
                    // Memory output holds while not read, so the presented word stays valid.
                    inflight_d = inflight_q;
                end else begin
                    RE_mem1    = 1'b1;
                    pc_d       = pc_plus4;
                    if_pc_d    = pc_q;
                    if_pc4_d   = pc_plus4;
                    inflight_d = 1'b1;
                end
            end
            StFault: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = StRun;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            if_pc_q    <= 32'd0;
            if_pc4_q   <= 32'd0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
            inflight_q <= inflight_d;
        end
    end

    assign imem_addr   = {2'b00, pc_q[31:2]};
    assign if_instr    = imem_data;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc4_q;
    assign fetch_fault = (state_q == StFault);
    assign if_valid    = inflight_q && (state_q != StFault);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: registered 64-word memory image, a PC-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        RE_mem1;
    logic [31:0] imem_addr;
    logic [31:0] mem_q;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        fetch_fault;

    int n_pass  = 0;
    int n_total = 0;

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_DEPTH(64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_in      (stall_in),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .RE_mem1       (RE_mem1),
        .imem_addr     (imem_addr),
        .imem_data     (mem_q),
        .if_valid      (if_valid),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    // Memory image: word n holds 0x1000_0000 + n, one-cycle registered read.
    always @(posedge clk) begin
        if (RE_mem1) mem_q <= 32'h1000_0000 + imem_addr;
    end

    function automatic void chk(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        else n_pass++;
    endfunction

    function automatic void chk1(input string name, input logic got, input logic exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        else n_pass++;
    endfunction

    // Reference model in terms of fetch PC, presented PC and fault/boot flags.
    bit          m_booted, m_fault, m_valid, m_bad, m_re;
    logic [31:0] m_pc, m_ipc, m_ipc4;

    always @(negedge clk) begin
        if (rst) begin
            m_booted = 0; m_fault = 0; m_valid = 0;
            m_pc = 32'd0; m_ipc = 32'd0; m_ipc4 = 32'd0;
        end
        m_bad = (m_pc % 4 != 0) || (m_pc / 4 >= 64);
        m_re  = m_booted && !m_fault && !stall_in && !redirect_valid && !m_bad;
        chk1("m_re", RE_mem1, m_re);
        chk("m_addr", imem_addr, m_pc / 4);
        chk1("m_valid", if_valid, m_valid);
        chk1("m_fault", fetch_fault, m_fault);
        chk("m_if_pc", if_pc, m_ipc);
        chk("m_if_pc_plus4", if_pc_plus4, m_ipc4);
        if (m_valid) chk("m_instr", if_instr, 32'h1000_0000 + m_ipc / 4);
        if (!rst) begin
            if (!m_booted) m_booted = 1;
            else if (redirect_valid) begin
                m_pc = redirect_pc; m_valid = 0; m_fault = 0;
            end else if (m_fault) begin
                m_fault = 1;
            end else if (m_bad) begin
                m_fault = 1; m_valid = 0;
            end else if (!stall_in) begin
                m_ipc = m_pc; m_ipc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
            end
        end
    end

    task automatic step(input logic s, input logic r, input logic [31:0] rp);
        @(posedge clk);
        #1;
        stall_in       = s;
        redirect_valid = r;
        redirect_pc    = rp;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_re"}, RE_mem1, 1'b0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk1({tag, "_valid"}, if_valid, 1'b0);
        chk({tag, "_if_pc"}, if_pc, 32'd0);
        chk({tag, "_if_pc_plus4"}, if_pc_plus4, 32'd0);
        chk1({tag, "_fault"}, fetch_fault, 1'b0);
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("d_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("d_boot_re", RE_mem1, 1'b0);

        // Cycles 2..6 after release: straight-line fetch from 0.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'd0);
            chk1("d_seq_re", RE_mem1, 1'b1);
            chk("d_seq_addr", imem_addr, 32'(i));
            if (i >= 1) begin
                chk1("d_seq_valid", if_valid, 1'b1);
                chk("d_seq_instr", if_instr, 32'h1000_0000 + 32'(i - 1));
                chk("d_seq_pc", if_pc, 32'(4 * (i - 1)));
                chk("d_seq_pc4", if_pc_plus4, 32'(4 * i));
            end
        end

        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0);
            chk1("d_stall_re", RE_mem1, 1'b0);
            chk1("d_stall_valid", if_valid, 1'b1);
            chk("d_stall_instr", if_instr, 32'h1000_0004);
            chk("d_stall_pc", if_pc, 32'h10);
        end
        step(1'b0, 1'b0, 32'd0);
        chk1("d_unstall_re", RE_mem1, 1'b1);
        chk("d_unstall_addr", imem_addr, 32'd5);
        chk("d_unstall_pc", if_pc, 32'h10);
        step(1'b0, 1'b0, 32'd0);
        chk("d_unstall_next_pc", if_pc, 32'h14);
        chk("d_unstall_next_instr", if_instr, 32'h1000_0005);

        step(1'b1, 1'b1, 32'h20);
        chk1("d_redir_re", RE_mem1, 1'b0);
        step(1'b0, 1'b0, 32'd0);
        chk1("d_redir_bubble_valid", if_valid, 1'b0);
        chk("d_redir_addr", imem_addr, 32'd8);
        chk1("d_redir_issue", RE_mem1, 1'b1);
        step(1'b0, 1'b0, 32'd0);
        chk("d_redir_instr", if_instr, 32'h1000_0008);
        chk("d_redir_pc", if_pc, 32'h20);

        found = 0;
        for (int k = 0; k < 80; k++) begin
            step(1'b0, 1'b0, 32'd0);
            if (if_valid === 1'b1 && if_pc === 32'hFC) begin
                found = 1;
                break;
            end
        end
        chk1("d_fc_reached", found, 1'b1);
        chk("d_fc_instr", if_instr, 32'h1000_003F);
        chk1("d_fc_re", RE_mem1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 32'd0);
            chk1("d_falloff_fault", fetch_fault, 1'b1);
            chk1("d_falloff_valid", if_valid, 1'b0);
            chk1("d_falloff_re", RE_mem1, 1'b0);
        end
        step(1'b0, 1'b1, 32'h4);
        chk1("d_clear_fault_same", fetch_fault, 1'b1);
        step(1'b0, 1'b0, 32'd0);
        chk1("d_clear_fault", fetch_fault, 1'b0);
        chk1("d_clear_re", RE_mem1, 1'b1);
        chk("d_clear_addr", imem_addr, 32'd1);
        step(1'b0, 1'b0, 32'd0);
        chk("d_clear_instr", if_instr, 32'h1000_0001);
        chk("d_clear_pc", if_pc, 32'h4);
        chk("d_clear_pc4", if_pc_plus4, 32'h8);

        step(1'b0, 1'b1, 32'h102);
        step(1'b0, 1'b0, 32'd0);
        chk1("d_mis_re", RE_mem1, 1'b0);
        chk1("d_mis_fault_early", fetch_fault, 1'b0);
        step(1'b0, 1'b0, 32'd0);
        chk1("d_mis_fault", fetch_fault, 1'b1);
        chk1("d_mis_re2", RE_mem1, 1'b0);

        step(1'b0, 1'b1, 32'h10);
        repeat (3) step(1'b0, 1'b0, 32'd0);

        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_reset_vals("d_async");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("d_async_boot_re", RE_mem1, 1'b0);
        step(1'b0, 1'b0, 32'd0);
        chk1("d_async_re", RE_mem1, 1'b1);
        chk("d_async_addr", imem_addr, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk1("d_async_valid", if_valid, 1'b1);
        chk("d_async_instr", if_instr, 32'h1000_0000);
        chk("d_async_pc4", if_pc_plus4, 32'h4);
        step(1'b0, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
